// File: rtl/hub75_scan_ctrl.sv
// rtl/hub75_scan_ctrl.sv - HUB75 read-side scan sequencer with BCM timing and frame-boundary buffer swap
// Outputs are registered from next-state values, so every output lines up with the visible state.
module hub75_scan_ctrl #(
    parameter int N_ROWS_MAX       = 64,
    parameter int N_COLS_MAX       = 256,
    parameter int BITDEPTH_MAX     = 8,
    parameter int CTRL_REG_WIDTH   = 32,
    parameter int DISPLAY_BASE     = 4,
    parameter int ROW_W            = $clog2(N_ROWS_MAX / 2),
    parameter int COL_W            = $clog2(N_COLS_MAX),
    parameter int MEM_R_ADDR_WIDTH = ROW_W + COL_W
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               ctrl_en,
    input  logic [CTRL_REG_WIDTH-1:0]          ctrl_bitdepth,
    input  logic                               swap_req,
    output logic                               swap_ack,
    output logic                               frame_done,
    output logic                               fb_r_en,
    output logic                               fb_r_buffer,
    output logic [MEM_R_ADDR_WIDTH-1:0]        fb_r_addr,
    output logic [$clog2(BITDEPTH_MAX)-1:0]    fb_r_bit,
    input  logic [5:0]                         fb_r_dout,
    output logic [5:0]                         hub_rgb,
    output logic                               hub_clk,
    output logic                               hub_lat,
    output logic                               hub_oe_n,
    output logic [ROW_W-1:0]                   hub_addr
);

    localparam int BIT_W     = $clog2(BITDEPTH_MAX);
    localparam int SHIFT_LEN = 2 * N_COLS_MAX + 2;
    localparam int DISP_MAX  = DISPLAY_BASE << (BITDEPTH_MAX - 1);
    localparam int CNT_MAX   = (SHIFT_LEN > DISP_MAX) ? SHIFT_LEN : DISP_MAX;
    localparam int CNT_W     = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT,
        S_LATCH,
        S_DISPLAY,
        S_ADVANCE
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [ROW_W-1:0]       row_q, row_d;
    logic [BIT_W-1:0]       bit_q, bit_d;
    logic [BIT_W-1:0]       bit_last_q, bit_last_d;

    logic                   fb_r_en_q, fb_r_en_d;
    logic                   fb_r_buffer_q, fb_r_buffer_d;
    logic [MEM_R_ADDR_WIDTH-1:0] fb_r_addr_q, fb_r_addr_d;
    logic [BIT_W-1:0]       fb_r_bit_q, fb_r_bit_d;
    logic [5:0]             hub_rgb_q, hub_rgb_d;
    logic                   hub_clk_q, hub_clk_d;
    logic                   hub_lat_q, hub_lat_d;
    logic                   hub_oe_n_q, hub_oe_n_d;
    logic [ROW_W-1:0]       hub_addr_q, hub_addr_d;
    logic                   frame_done_q, frame_done_d;
    logic                   swap_ack_q, swap_ack_d;

    logic                   frame_last;
    logic                   frame_end_c;
    logic                   swap_c;
    logic [CNT_W-1:0]       disp_last;

    // Out-of-range plane counts fall back to the full depth.
    function automatic logic [BIT_W-1:0] plane_last(input logic [CTRL_REG_WIDTH-1:0] bd);
        if (bd != '0 && bd <= CTRL_REG_WIDTH'(BITDEPTH_MAX))
            return BIT_W'(bd - 1'b1);
        else
            return BIT_W'(BITDEPTH_MAX - 1);
    endfunction

    assign frame_last = (&row_q) && (bit_q == bit_last_q);
    assign disp_last  = CNT_W'((DISPLAY_BASE << bit_q) - 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            row_q      <= '0;
            bit_q      <= '0;
            bit_last_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            row_q      <= row_d;
            bit_q      <= bit_d;
            bit_last_q <= bit_last_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        row_d       = row_q;
        bit_d       = bit_q;
        bit_last_d  = bit_last_q;
        frame_end_c = 1'b0;
        swap_c      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (ctrl_en) begin
                    state_d    = S_SHIFT;
                    cnt_d      = '0;
                    bit_last_d = plane_last(ctrl_bitdepth);
                end
            end
            S_SHIFT: begin
                if (cnt_q == CNT_W'(SHIFT_LEN - 1)) begin
                    state_d = S_LATCH;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_LATCH: begin
                state_d = S_DISPLAY;
                cnt_d   = '0;
            end
            S_DISPLAY: begin
                if (cnt_q == disp_last) begin
                    state_d     = S_ADVANCE;
                    frame_end_c = frame_last;
                    swap_c      = frame_last && swap_req;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_ADVANCE: begin
                cnt_d = '0;
                if (bit_q == bit_last_q) begin
                    bit_d = '0;
                    row_d = row_q + 1'b1;
                end else begin
                    bit_d = bit_q + 1'b1;
                end
                state_d = S_SHIFT;
                if (frame_last) begin
                    if (ctrl_en)
                        bit_last_d = plane_last(ctrl_bitdepth);
                    else
                        state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Column c is read at t=2c and its data arrives one cycle later at t=2c+1.
    always_comb begin
        fb_r_en_d     = (state_d == S_SHIFT) && !cnt_d[0] && (cnt_d < CNT_W'(2 * N_COLS_MAX));
        fb_r_addr_d   = fb_r_en_d ? {row_d, cnt_d[COL_W:1]} : fb_r_addr_q;
        fb_r_bit_d    = fb_r_en_d ? bit_d : fb_r_bit_q;
        fb_r_buffer_d = fb_r_buffer_q ^ swap_c;
        hub_rgb_d     = hub_rgb_q;
        if ((state_q == S_SHIFT) && cnt_q[0] && (cnt_q < CNT_W'(2 * N_COLS_MAX)))
            hub_rgb_d = fb_r_dout;
        hub_clk_d     = (state_d == S_SHIFT) && cnt_d[0] && (cnt_d >= CNT_W'(3));
        hub_lat_d     = (state_d == S_LATCH);
        hub_oe_n_d    = (state_d != S_DISPLAY);
        hub_addr_d    = (state_d == S_LATCH) ? row_d : hub_addr_q;
        frame_done_d  = frame_end_c;
        swap_ack_d    = swap_c;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fb_r_en_q     <= 1'b0;
            fb_r_buffer_q <= 1'b0;
            fb_r_addr_q   <= '0;
            fb_r_bit_q    <= '0;
            hub_rgb_q     <= '0;
            hub_clk_q     <= 1'b0;
            hub_lat_q     <= 1'b0;
            hub_oe_n_q    <= 1'b1;
            hub_addr_q    <= '0;
            frame_done_q  <= 1'b0;
            swap_ack_q    <= 1'b0;
        end else begin
            fb_r_en_q     <= fb_r_en_d;
            fb_r_buffer_q <= fb_r_buffer_d;
            fb_r_addr_q   <= fb_r_addr_d;
            fb_r_bit_q    <= fb_r_bit_d;
            hub_rgb_q     <= hub_rgb_d;
            hub_clk_q     <= hub_clk_d;
            hub_lat_q     <= hub_lat_d;
            hub_oe_n_q    <= hub_oe_n_d;
            hub_addr_q    <= hub_addr_d;
            frame_done_q  <= frame_done_d;
            swap_ack_q    <= swap_ack_d;
        end
    end

    assign fb_r_en     = fb_r_en_q;
    assign fb_r_buffer = fb_r_buffer_q;
    assign fb_r_addr   = fb_r_addr_q;
    assign fb_r_bit    = fb_r_bit_q;
    assign hub_rgb     = hub_rgb_q;
    assign hub_clk     = hub_clk_q;
    assign hub_lat     = hub_lat_q;
    assign hub_oe_n    = hub_oe_n_q;
    assign hub_addr    = hub_addr_q;
    assign frame_done  = frame_done_q;
    assign swap_ack    = swap_ack_q;

endmodule

// File: tb/tb_hub75_scan_ctrl.sv
// tb/tb_hub75_scan_ctrl.sv - randomized frame-level bench for hub75_scan_ctrl against a nested-loop scan model
module tb_hub75_scan_ctrl;

    localparam int NR = 4;
    localparam int NC = 4;
    localparam int BD = 2;
    localparam int DB = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ctrl_en = 1'b0;
    logic [31:0] ctrl_bitdepth = '0;
    logic        swap_req = 1'b0;
    logic        swap_ack, frame_done, fb_r_en, fb_r_buffer;
    logic [2:0]  fb_r_addr;
    logic [0:0]  fb_r_bit;
    logic [5:0]  fb_r_dout = '0;
    logic [5:0]  hub_rgb;
    logic        hub_clk, hub_lat, hub_oe_n;
    logic [0:0]  hub_addr;

    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc_idx = 0;
    int   rst_at = -1;
    bit   abort = 0;
    bit   pat_fixed = 0;
    int   seed = 0;
    int   cur_bd = 2;
    int   frame_no = 0;
    logic exp_buf = 1'b0;
    int   exp_rgb = 0;
    int   exp_haddr = 0;

    hub75_scan_ctrl #(
        .N_ROWS_MAX(NR), .N_COLS_MAX(NC), .BITDEPTH_MAX(BD),
        .CTRL_REG_WIDTH(32), .DISPLAY_BASE(DB)
    ) dut (
        .clk(clk), .rst(rst), .ctrl_en(ctrl_en), .ctrl_bitdepth(ctrl_bitdepth),
        .swap_req(swap_req), .swap_ack(swap_ack), .frame_done(frame_done),
        .fb_r_en(fb_r_en), .fb_r_buffer(fb_r_buffer), .fb_r_addr(fb_r_addr),
        .fb_r_bit(fb_r_bit), .fb_r_dout(fb_r_dout), .hub_rgb(hub_rgb),
        .hub_clk(hub_clk), .hub_lat(hub_lat), .hub_oe_n(hub_oe_n), .hub_addr(hub_addr)
    );

    always #5 clk = ~clk;

    function automatic logic [5:0] pix(input logic b, input int r, input int c, input int p);
        if (pat_fixed) return 6'b101010;
        return 6'((seed + int'(b) * 37 + r * 11 + c * 5 + p * 23) ^ (c << 3));
    endfunction

    function automatic int eff_nb(input int bd);
        return (bd >= 1 && bd <= BD) ? bd : BD;
    endfunction

    // Framebuffer with one cycle of read latency.
    always @(posedge clk)
        if (fb_r_en) fb_r_dout <= pix(fb_r_buffer, int'(fb_r_addr) / NC, int'(fb_r_addr) % NC, int'(fb_r_bit));

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %05h want %05h", tag, obs, exp);
        end
    endtask

    // Vector: {en, addr[2:0], bit, buffer, rgb[5:0], hub_clk, lat, oe_n, hub_addr, frame_done, swap_ack}
    task automatic step(input string tag, input logic en, input int addr, input int bitv, input int rgb,
                        input logic hclk, input logic lat, input logic oe_n, input int haddr,
                        input logic fd, input logic sack);
        logic [17:0] o, e;
        if (abort) return;
        @(negedge clk);
        o = {fb_r_en, en ? fb_r_addr : 3'b0, en ? fb_r_bit : 1'b0, fb_r_buffer, hub_rgb,
             hub_clk, hub_lat, hub_oe_n, hub_addr, frame_done, swap_ack};
        e = {en, en ? 3'(addr) : 3'b0, en ? 1'(bitv) : 1'b0, exp_buf, 6'(rgb),
             hclk, lat, oe_n, 1'(haddr), fd, sack};
        check_eq(tag, 32'(o), 32'(e));
        cyc_idx++;
        if (cyc_idx == rst_at) begin
            rst = 1'b1;
            ctrl_en = 1'b0;
            swap_req = 1'b0;
            abort = 1;
        end
    endtask

    task automatic idle_step(input string tag);
        step(tag, 1'b0, 0, 0, exp_rgb, 1'b0, 1'b0, 1'b1, exp_haddr, 1'b0, 1'b0);
    endtask

    task automatic model_reset();
        exp_buf = 1'b0;
        exp_rgb = 0;
        exp_haddr = 0;
    endtask

    task automatic start(input int bd);
        ctrl_bitdepth = 32'(bd);
        ctrl_en = 1'b1;
        cur_bd = bd;
    endtask

    task automatic run_frame(input int next_bd, input bit sw, input bit sw_drop, input bit en_after);
        int   nb, rgb;
        logic fd, sa;
        string tg;
        nb = eff_nb(cur_bd);
        for (int r = 0; r < NR / 2; r++) begin
            for (int b = 0; b < nb; b++) begin
                for (int t = 0; t < 2 * NC + 2; t++) begin
                    rgb = (t >= 2) ? int'(pix(exp_buf, r, (t - 2) / 2, b)) : exp_rgb;
                    tg = $sformatf("f%0d r%0d b%0d shift t%0d", frame_no, r, b, t);
                    step(tg, (t % 2 == 0) && (t < 2 * NC), r * NC + t / 2, b, rgb,
                         (t % 2 == 1) && (t >= 3), 1'b0, 1'b1, exp_haddr, 1'b0, 1'b0);
                    if (t >= 2) exp_rgb = rgb;
                    if (r == 0 && b == 0 && t == 4) begin
                        if (sw) swap_req = 1'b1;
                        if (!en_after) ctrl_en = 1'b0;
                    end
                    if (r == NR / 2 - 1 && b == 0 && t == 4) begin
                        if (sw_drop) swap_req = 1'b0;
                        ctrl_bitdepth = 32'(next_bd);
                    end
                end
                exp_haddr = r;
                step($sformatf("f%0d r%0d b%0d latch", frame_no, r, b), 1'b0, 0, 0, exp_rgb,
                     1'b0, 1'b1, 1'b1, exp_haddr, 1'b0, 1'b0);
                for (int d = 0; d < (DB << b); d++)
                    step($sformatf("f%0d r%0d b%0d disp d%0d", frame_no, r, b, d), 1'b0, 0, 0, exp_rgb,
                         1'b0, 1'b0, 1'b0, exp_haddr, 1'b0, 1'b0);
                fd = (r == NR / 2 - 1) && (b == nb - 1);
                sa = fd && swap_req;
                if (sa) exp_buf = ~exp_buf;
                step($sformatf("f%0d r%0d b%0d advance", frame_no, r, b), 1'b0, 0, 0, exp_rgb,
                     1'b0, 1'b0, 1'b1, exp_haddr, fd, sa);
            end
        end
        swap_req = 1'b0;
        cur_bd = next_bd;
        frame_no++;
    endtask

    initial begin
        int nbd;
        bit sw;
        seed = int'($urandom_range(0, 63));
        rst = 1'b1;
        repeat (2) @(negedge clk);
        model_reset();
        idle_step("reset0");
        idle_step("reset1");
        rst = 1'b0;
        idle_step("idle0");
        idle_step("idle1");

        start(2);
        run_frame(2, 0, 0, 1);
        pat_fixed = 1;
        run_frame(2, 0, 0, 1);
        pat_fixed = 0;
        run_frame(2, 1, 0, 1);
        run_frame(2, 0, 0, 1);
        run_frame(0, 1, 1, 1);
        run_frame(7, 0, 0, 1);
        run_frame(1, 0, 0, 1);
        run_frame(-1, 1, 0, 1);
        for (int i = 0; i < 6; i++) begin
            nbd = int'($urandom_range(0, 9));
            sw  = 1'($urandom_range(0, 1));
            run_frame(nbd, sw, sw && ($urandom_range(0, 2) == 0), 1);
        end
        run_frame(2, 1'($urandom_range(0, 1)), 0, 0);
        repeat (4) idle_step("idle after stop");

        start(int'($urandom_range(1, 2)));
        run_frame(2, 1, 0, 1);
        rst_at = cyc_idx + 2 * NC + 4;
        run_frame(2, 0, 0, 1);
        abort = 0;
        rst_at = -1;
        model_reset();
        idle_step("reset mid display");
        rst = 1'b0;
        idle_step("idle after reset");
        start(2);
        run_frame(2, 0, 0, 0);
        repeat (3) idle_step("final idle");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1);
    end

endmodule

// File: doc/hub75_scan_ctrl.md
Name: hub75_scan_ctrl

Overview:
Read-side sequencer for the double-buffered LED framebuffer.
- Walks scan rows, bit planes and columns, and issues framebuffer read addresses.
- Shifts the returned 6-bit pixel slices out on the HUB75 panel interface, then latches and enables the row for a binary-weighted (BCM) display time.
- Owns front-buffer selection: swaps buffers only at frame boundaries, on request from the writer.

Parameters:
- N_ROWS_MAX, 64, total panel rows; power of two, >=4. Scan rows = N_ROWS_MAX/2.
- N_COLS_MAX, 256, total chained columns; power of two.
- BITDEPTH_MAX, 8, maximum bits per colour.
- CTRL_REG_WIDTH, 32, width of control registers.
- DISPLAY_BASE, 4, clk cycles of OE for bit plane 0.
- ROW_W, $clog2(N_ROWS_MAX/2), scan-row address width.
- COL_W, $clog2(N_COLS_MAX), column index width.
- MEM_R_ADDR_WIDTH, ROW_W+COL_W, framebuffer read address width.

Ports:
- clk  in  1  single clock; framebuffer read port runs on it.
- rst  in  1  synchronous, active-high reset.
- ctrl_en  in  1  scan enable.
- ctrl_bitdepth  in  CTRL_REG_WIDTH  bit planes per frame.
- swap_req  in  1  level; writer has finished the back buffer.
- swap_ack  out  1  one-cycle pulse when the buffers are swapped.
- frame_done  out  1  one-cycle pulse at the end of each frame.
- fb_r_en  out  1  framebuffer read enable.
- fb_r_buffer  out  1  front buffer index.
- fb_r_addr  out  MEM_R_ADDR_WIDTH  {row, col}.
- fb_r_bit  out  $clog2(BITDEPTH_MAX)  bit plane index.
- fb_r_dout  in  6  {R0,G0,B0,R1,G1,B1}; valid 1 cycle after fb_r_en.
- hub_rgb  out  6  panel data {R0,G0,B0,R1,G1,B1}.
- hub_clk  out  1  panel shift clock.
- hub_lat  out  1  panel latch.
- hub_oe_n  out  1  panel output enable, active low.
- hub_addr  out  ROW_W  panel row select.

Behaviour:
- Reset values:
  - State IDLE.
  - hub_oe_n=1.
  - All other outputs 0, including fb_r_buffer=0 and hub_addr=0.
  - Row, bit and column counters 0.
  - rst mid-operation aborts immediately.
- All outputs are registered.
- State machine: IDLE -> SHIFT -> LATCH -> DISPLAY -> ADVANCE -> SHIFT | IDLE.
- IDLE:
  - hub_oe_n=1.
  - If ctrl_en=1: sample ctrl_bitdepth into nbits, go to SHIFT next cycle.
  - nbits = ctrl_bitdepth when 1..BITDEPTH_MAX; any other value gives BITDEPTH_MAX.
- SHIFT lasts exactly 2*N_COLS_MAX+2 cycles; t=0 is the first cycle.
  - Reads:
    - At even t=2c, c<N_COLS_MAX: fb_r_en=1, fb_r_addr={row,c}, fb_r_bit=bit.
    - fb_r_en=0 on all other cycles.
  - Data: hub_rgb is loaded from fb_r_dout at the end of t=2c+1, so it holds pixel c during t=2c+2 and t=2c+3.
  - Shift clock: hub_clk=1 only on odd t>=3; it rises with data stable for 1 cycle.
  - hub_oe_n=1 and hub_lat=0 throughout SHIFT.
- LATCH:
  - 1 cycle: hub_lat=1, hub_addr=row, hub_oe_n=1, hub_clk=0.
- DISPLAY:
  - hub_oe_n=0 for exactly DISPLAY_BASE<<bit cycles.
  - hub_addr and hub_rgb are held.
- ADVANCE:
  - 1 cycle, hub_oe_n=1.
  - Counter update: if bit<nbits-1, increment bit; else bit=0 and row increments.
  - Frame end is reached when row wraps from N_ROWS_MAX/2-1 to 0.
- Frame end:
  - frame_done=1 for this one cycle.
  - If swap_req=1: toggle fb_r_buffer and pulse swap_ack in the same cycle.
  - If ctrl_en=0: go to IDLE; otherwise resample ctrl_bitdepth and go to SHIFT.
- Mid-frame rules:
  - ctrl_en=0 mid-frame does not abort; the frame completes first.
  - fb_r_buffer never changes mid-frame.
  - swap_req deasserted before frame end means no swap.
- Frame cycle count = (N_ROWS_MAX/2)*sum over b<nbits of (2*N_COLS_MAX+4+(DISPLAY_BASE<<b)).

Test Plan:
All scenarios use N_ROWS_MAX=4, N_COLS_MAX=4, BITDEPTH_MAX=2, DISPLAY_BASE=2, with a memory model of 1-cycle latency.
1. Release rst, ctrl_en=1, ctrl_bitdepth=2:
   - first SHIFT reads addr 0,1,2,3 at t=0,2,4,6 with fb_r_bit=0;
   - hub_clk high at t=3,5,7,9;
   - LATCH at t=10 with hub_addr=0;
   - hub_oe_n=0 for 2 cycles.
2. Full frame: frame_done pulses every 60 cycles. Row 1 uses addr 4..7. Bit 1 DISPLAY lasts 4 cycles.
3. Memory returns pixel value = column index pattern {3'b101,3'b010} -> hub_rgb=6'b101010 while hub_clk high for every column.
4. Swap: assert swap_req mid-frame ->
   - fb_r_buffer stays 0 until frame_done;
   - fb_r_buffer becomes 1 with a swap_ack pulse in the same cycle;
   - with no swap_req at the next frame end, fb_r_buffer stays 1.
5. Control edge cases:
   - ctrl_bitdepth=0 or 7 -> behaves as 2 planes (60-cycle frame);
   - ctrl_en dropped mid-frame -> the frame finishes, then IDLE with hub_oe_n=1.
6. Assert rst during DISPLAY -> next cycle IDLE, hub_oe_n=1, fb_r_buffer=0, counters 0; restart reproduces scenario 1 timing.
